// File: rtl/dog_window_gen.sv
// rtl/dog_window_gen.sv - 3x3x3 DoG cube window generator feeding the extremum detectors
// Optional macro COORD_OUT_EN adds registered centre-coordinate outputs oX/oY.
module dog_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic                          iSof,
  input  logic                          iValid,
  input  logic [DATA_W-1:0]             iData_s0,
  input  logic [DATA_W-1:0]             iData_s1,
  input  logic [DATA_W-1:0]             iData_s2,
  output logic                          oValid,
  output logic [DATA_W-1:0]             oData_a,
  output logic [DATA_W-1:0]             oData_b0,
  output logic [DATA_W-1:0]             oData_b1,
  output logic [DATA_W-1:0]             oData_b2,
  output logic [DATA_W-1:0]             oData_b3,
  output logic [DATA_W-1:0]             oData_b4,
  output logic [DATA_W-1:0]             oData_b5,
  output logic [DATA_W-1:0]             oData_b6,
  output logic [DATA_W-1:0]             oData_b7,
  output logic [DATA_W-1:0]             oData_b8,
  output logic [DATA_W-1:0]             oData_b9,
  output logic [DATA_W-1:0]             oData_b10,
  output logic [DATA_W-1:0]             oData_b11,
  output logic [DATA_W-1:0]             oData_b12,
  output logic [DATA_W-1:0]             oData_b13,
  output logic [DATA_W-1:0]             oData_b14,
  output logic [DATA_W-1:0]             oData_b15,
  output logic [DATA_W-1:0]             oData_b16,
  output logic [DATA_W-1:0]             oData_b17,
  output logic [DATA_W-1:0]             oData_b18,
  output logic [DATA_W-1:0]             oData_b19,
  output logic [DATA_W-1:0]             oData_b20,
  output logic [DATA_W-1:0]             oData_b21,
  output logic [DATA_W-1:0]             oData_b22,
  output logic [DATA_W-1:0]             oData_b23,
  output logic [DATA_W-1:0]             oData_b24,
  output logic [DATA_W-1:0]             oData_b25,
  output logic [DATA_W-1:0]             oData_b26
`ifdef COORD_OUT_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  oX,
  output logic [$clog2(IMG_HEIGHT)-1:0] oY
`endif
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  logic [XW-1:0]     col_q, col_d, cur_col;
  logic [YW-1:0]     row_q, row_d, cur_row;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pix [3];
  logic [DATA_W-1:0] lb1_q [3][IMG_WIDTH];
  logic [DATA_W-1:0] lb2_q [3][IMG_WIDTH];
  logic [DATA_W-1:0] win_q [27];
  logic [DATA_W-1:0] win_d [27];
  logic [DATA_W-1:0] cube_q [27];
  logic [DATA_W-1:0] cube_d [27];

  assign pix[0] = iData_s0;
  assign pix[1] = iData_s1;
  assign pix[2] = iData_s2;

  always_comb begin
    cur_col = iSof ? '0 : col_q;
    cur_row = iSof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    win_d   = win_q;
    cube_d  = cube_q;
    if (iValid) begin
      if (cur_col == XW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == YW'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      // Window index 9s+3r+c; the new right column is {LB2, LB1, input} top to bottom.
      for (int s = 0; s < 3; s++) begin
        for (int r = 0; r < 3; r++) begin
          win_d[9*s+3*r]   = win_q[9*s+3*r+1];
          win_d[9*s+3*r+1] = win_q[9*s+3*r+2];
        end
        win_d[9*s+2] = lb2_q[s][cur_col];
        win_d[9*s+5] = lb1_q[s][cur_col];
        win_d[9*s+8] = pix[s];
      end
      valid_d = (cur_col >= XW'(2)) && (cur_row >= YW'(2));
      if (valid_d) cube_d = win_d;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= '{default: '0};
      cube_q  <= '{default: '0};
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      win_q   <= win_d;
      cube_q  <= cube_d;
    end
  end

  // Read-before-write: LB2 receives the old LB1 entry in the same cycle LB1 takes the input.
  always_ff @(posedge iclk) begin
    if (iValid) begin
      for (int s = 0; s < 3; s++) begin
        lb2_q[s][cur_col] <= lb1_q[s][cur_col];
        lb1_q[s][cur_col] <= pix[s];
      end
    end
  end

`ifdef COORD_OUT_EN
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (valid_d) begin
      x_d = cur_col - 1'b1;
      y_d = cur_row - 1'b1;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign oX = x_q;
  assign oY = y_q;
`endif

  assign oValid    = valid_q;
  assign oData_a   = cube_q[13];
  assign oData_b0  = cube_q[0];
  assign oData_b1  = cube_q[1];
  assign oData_b2  = cube_q[2];
  assign oData_b3  = cube_q[3];
  assign oData_b4  = cube_q[4];
  assign oData_b5  = cube_q[5];
  assign oData_b6  = cube_q[6];
  assign oData_b7  = cube_q[7];
  assign oData_b8  = cube_q[8];
  assign oData_b9  = cube_q[9];
  assign oData_b10 = cube_q[10];
  assign oData_b11 = cube_q[11];
  assign oData_b12 = cube_q[12];
  assign oData_b13 = cube_q[13];
  assign oData_b14 = cube_q[14];
  assign oData_b15 = cube_q[15];
  assign oData_b16 = cube_q[16];
  assign oData_b17 = cube_q[17];
  assign oData_b18 = cube_q[18];
  assign oData_b19 = cube_q[19];
  assign oData_b20 = cube_q[20];
  assign oData_b21 = cube_q[21];
  assign oData_b22 = cube_q[22];
  assign oData_b23 = cube_q[23];
  assign oData_b24 = cube_q[24];
  assign oData_b25 = cube_q[25];
  assign oData_b26 = cube_q[26];

endmodule

// File: doc/dog_window_gen.md
Name: dog_window_gen

Overview:
- Source end of the 3x3x3 extremum-detection interface: takes three adjacent DoG scale streams (raster order, one pixel per valid cycle) and emits, per interior position, the centre sample plus the full 27-sample cube consumed by the minimum/maximum detectors.
- Sits between the DoG subtractors and the extrema detectors.
- Holds two line buffers and one 3x3 shift window per scale.
- Keeps column/row counters so only fully-populated windows are marked valid.

Parameters:
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)
DATA_W, 8, bits per DoG sample

Ports:
iclk  in  1  clock
irst  in  1  reset, asynchronous, active-high
iSof  in  1  start of frame; qualified by iValid, marks pixel (0,0)
iValid  in  1  input pixel valid (no backpressure; gaps allowed)
iData_s0  in  DATA_W  DoG scale k-1 sample
iData_s1  in  DATA_W  DoG scale k sample (centre scale)
iData_s2  in  DATA_W  DoG scale k+1 sample
oValid  out  1  cube valid, one-cycle pulse per interior position
oData_a  out  DATA_W  centre sample (scale s1, window middle)
oData_b0..oData_b26  out  DATA_W each  cube samples, index = 9*s + 3*r + c
oX  out  clog2(IMG_WIDTH)  centre column (COORD_OUT_EN only)
oY  out  clog2(IMG_HEIGHT)  centre row (COORD_OUT_EN only)

Behaviour:
- Reset: all outputs 0; col/row counters 0; window registers 0; line-buffer contents don't-care; line-buffer write pointer 0.
- Clock and reset: all logic on iclk rising edge; irst is asynchronous, active-high, and may assert mid-frame. Deassertion resumes with counters at (0,0); the pixels already in the line buffers are treated as garbage, since no oValid fires until 2 new rows are filled.
- Counters advance only on iValid:
  - col 0..IMG_WIDTH-1, wraps to 0 and increments row.
  - row wraps to 0 after IMG_HEIGHT-1.
  - iSof with iValid forces the current pixel to (0,0); the next pixel is (1,0). This overrides wrap and resyncs a corrupt frame.
- Line buffers, per scale:
  - LB1 holds the previous row, LB2 the row before it, addressed by col.
  - On iValid, read LB1[col] and LB2[col], write LB2[col]<=LB1[col] and LB1[col]<=input in the same cycle (read-before-write).
- Window, per scale: 3 rows x 3 cols.
  - On iValid, columns shift left; the new right column is {LB2 out, LB1 out, input} as rows r=0,1,2 (r=0 oldest row).
  - c=0 is the oldest column.
  - iValid low: window, counters and buffers hold.
- Cube index mapping: b(9s+3r+c). b13 equals the centre (same value as oData_a) and is driven; consumers ignore or tolerate it.
- Validity: a window is valid after the pixel at (col,row) is written when col>=2 and row>=2. Its centre is then (col-1,row-1).
- Latency: oValid/oData/oX/oY are registered, one cycle after the qualifying iValid. oValid is low on any cycle following iValid=0.
- Line wrap: windows straddling col=IMG_WIDTH-1 -> col=0/1 are never valid, because the col>=2 gate suppresses them.
- Frame wrap: row 0/1 of a new frame never produce valid, even though stale rows remain in the buffers.
- Count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) oValid pulses per complete frame.

Optional Feature:
- COORD_OUT_EN defined:
  - oX/oY ports exist and carry the centre coordinate registered alongside oValid.
  - Reset value 0; they hold their value when oValid is low.
- Not defined: the oX/oY ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Param W=8,H=6; s0=x+8y, s1=64+x+8y, s2=128+x+8y, iValid always high -> exactly 24 oValid pulses. The first comes 1 cycle after pixel (2,2), with centre (1,1): oData_a=73, b0=0, b4=9, b8=18, b13=73, b26=146.
- Same frame, iValid toggling 1/0 -> identical oData sequence and 24 pulses; oValid is never high on the cycle after iValid=0.
- Check the end of each line -> no pulse when the window spans x=7 and x=0. oX (COORD_OUT_EN) runs 1..6 per row, oY runs 1..4.
- Two back-to-back frames -> frame 2 produces 24 pulses, the first centred (1,1) with frame-2 values (no frame-1 data in any valid output).
- Assert iSof at pixel index 20 of a frame -> counters resync: next pulse comes after 2 full rows plus 3 pixels, centred (1,1).
- Assert irst for 1 cycle mid-row 3 -> outputs immediately 0. After release, no oValid until the first new (2,2) pixel, then normal operation.
